mem_port_arbiter: RTL

Parametrised N-port arbiter that shares the single RAM port between requesters: instruction-cache fill, load/store path, and future DMA/debug masters. It replaces the combinational stall-driven address steering mux in the processor top. It arbitrates fixed-priority or round-robin, holds one transaction outstanding to a variable-latency memory, and routes the response back to the winning port.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/rr_select.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encoding, arbitration-mode constants and round-robin search helper
// for mem_port_arbiter and its winner selector.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arbState_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MaxPorts  = 8;

    // First valid port strictly above ptr, wrapping modulo numPorts; 0 when nothing is valid.
    function automatic logic [2:0] rrNext(input logic [MaxPorts-1:0] valid,
                                          input logic [2:0]          ptr,
                                          input int                  numPorts);
        logic [2:0] winner;
        logic       found;
        int         idx;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= MaxPorts; k++) begin
            idx = (int'(ptr) + k) % numPorts;
            if (k <= numPorts && !found && valid[3'(idx)]) begin
                winner = 3'(idx);
                found  = 1'b1;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational winner selector: fixed priority (lowest index) or round-robin
// starting one above the pointer. Produces a one-hot grant and the winner index.
module rr_select
    import mem_arb_pkg::*;
#(
    parameter int NumPorts = 2,
    parameter int IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] valid,
    input  logic [IdxW-1:0]     ptr,
    input  logic                mode,
    output logic [NumPorts-1:0] grant,
    output logic [IdxW-1:0]     winnerIdx
);

    logic [MaxPorts-1:0] validWide;
    logic [2:0]          ptrWide;
    logic [2:0]          rrWinner;

    always_comb begin
        validWide                = '0;
        validWide[NumPorts-1:0]  = valid;
        ptrWide                  = 3'(ptr);
    end

    assign rrWinner = rrNext(validWide, ptrWide, NumPorts);

    always_comb begin
        // NOTE: every output gets a default before any branch, otherwise an incomplete path infers a latch.
        winnerIdx = '0;
        grant     = '0;
        if (mode && NumPorts > 1) begin
            winnerIdx = IdxW'(rrWinner);
        end else begin
            for (int i = NumPorts - 1; i >= 0; i--) begin
                if (valid[i]) winnerIdx = IdxW'(i);
            end
        end
        if (|valid) grant[winnerIdx] = 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency RAM port among NumPorts requesters, one transaction in flight.
// Define MEM_ARB_STATS_EN to build saturating per-port grant counters on GrantCount.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32,
    parameter int NumPorts    = 2,
    parameter int ArbMode     = ARB_RR,
    parameter int StatW       = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NumPorts-1:0]             ReqValid,
    output logic [NumPorts-1:0]             ReqReady,
    input  logic [NumPorts-1:0]             ReqWrite,
    input  logic [NumPorts*RAMAddrSize-1:0] ReqAddr,
    input  logic [NumPorts*dataW-1:0]       ReqData,
    output logic [NumPorts-1:0]             RespValid,
    output logic [dataW-1:0]                RespData,
    output logic                            MemReq,
    output logic                            MemWrite,
    output logic [RAMAddrSize-1:0]          MemAddr,
    output logic [dataW-1:0]                MemDataIn,
    input  logic                            MemAck,
    input  logic [dataW-1:0]                MemDataOut,
    output logic [NumPorts*StatW-1:0]       GrantCount
);

    localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    arbState_t           state;
    logic [IdxW-1:0]     rrPtr;
    logic [IdxW-1:0]     latPort;
    logic [IdxW-1:0]     winnerIdx;
    logic [NumPorts-1:0] grant;
    logic                accept;

    rr_select #(
        .NumPorts (NumPorts),
        .IdxW     (IdxW)
    ) u_select (
        .valid     (ReqValid),
        .ptr       (rrPtr),
        .mode      (ArbMode != ARB_FIXED),
        .grant     (grant),
        .winnerIdx (winnerIdx)
    );

    // Reset also masks the handshake so every output reads 0 while reset is held.
    assign ReqReady = (state == IDLE && reset) ? grant : '0;
    assign accept   = |ReqReady;

    // MemAddr/MemWrite/MemDataIn double as the transaction latches and stay stable through BUSY.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rrPtr     <= IdxW'(NumPorts - 1);
            latPort   <= '0;
            MemReq    <= 1'b0;
            MemWrite  <= 1'b0;
            MemAddr   <= '0;
            MemDataIn <= '0;
            RespValid <= '0;
            RespData  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            case (state)
                IDLE: begin
                    if (accept) begin
                        MemAddr   <= ReqAddr[winnerIdx*RAMAddrSize +: RAMAddrSize];
                        MemDataIn <= ReqData[winnerIdx*dataW +: dataW];
                        MemWrite  <= ReqWrite[winnerIdx];
                        latPort   <= winnerIdx;
                        rrPtr     <= winnerIdx;
                        MemReq    <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (MemAck) begin
                        MemReq    <= 1'b0;
                        RespData  <= MemWrite ? '0 : MemDataOut;
                        RespValid <= NumPorts'(1) << latPort;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    RespValid <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            GrantCount <= '0;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                if (ReqReady[i] && GrantCount[i*StatW +: StatW] != {StatW{1'b1}})
                    GrantCount[i*StatW +: StatW] <= GrantCount[i*StatW +: StatW] + StatW'(1);
            end
        end
    end
`else
    assign GrantCount = '0;
`endif

endmodule
